// File: rtl/pc_sequencer.sv
// RV32I fetch sequencer: owns the PC, issues one-outstanding imem requests, buffers the
// returned word for decode and applies redirects/traps. Optional macro: PC_MISALIGN_TRAP_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        trap_req,
  output logic        trap_taken,
  output logic [31:0] bad_addr
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        trap_taken_q, trap_taken_d;

  logic        misalign;
  logic        take_trap;
  logic        flush;
  logic [31:0] redir_tgt;

`ifdef PC_MISALIGN_TRAP_EN
  logic [31:0] bad_addr_q, bad_addr_d;

  // An explicit trap_req outranks the redirect, so its target is never recorded then.
  assign misalign  = redirect_valid & ~trap_req & (redirect_target[1:0] != 2'b00);
  assign redir_tgt = redirect_target;
  assign bad_addr  = bad_addr_q;
`else
  assign misalign  = 1'b0;
  assign redir_tgt = redirect_target & 32'hFFFF_FFFC;
  assign bad_addr  = 32'h0000_0000;
`endif

  assign take_trap   = trap_req | misalign;
  assign flush       = trap_req | redirect_valid;
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign trap_taken  = trap_taken_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    kill_d        = kill_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    trap_taken_d  = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    bad_addr_d    = bad_addr_q;
    if (misalign) bad_addr_d = redirect_target;
`endif
    // Gated combinationally so a redirect never launches a fetch from the stale PC.
    imem_req = (state_q == S_REQ) & ~flush & ~rst;

    if (flush) begin
      if (take_trap) begin
        pc_d         = TRAP_VECTOR;
        trap_taken_d = 1'b1;
      end else begin
        pc_d = redir_tgt;
      end
      case (state_q)
        S_WAIT: begin
          // A response arriving with the redirect is itself the one being killed.
          if (imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d = 1'b1;
          end
        end
        S_HOLD: begin
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: if (imem_gnt) state_d = S_WAIT;
        S_WAIT: begin
          if (imem_rvalid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              instr_d       = imem_rdata;
              instr_pc_d    = pc_q;
              pc_d          = pc_q + 32'd4;
              instr_valid_d = 1'b1;
              state_d       = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            instr_valid_d = 1'b0;
            state_d       = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_VECTOR;
      kill_q        <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
      trap_taken_q  <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      bad_addr_q    <= 32'h0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      kill_q        <= kill_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      trap_taken_q  <= trap_taken_d;
`ifdef PC_MISALIGN_TRAP_EN
      bad_addr_q    <= bad_addr_d;
`endif
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a driver with an instruction-memory model pushes
// redirect/trap outcomes into a queue; a monitor tracks the expected instruction stream.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_req;
  logic        trap_taken;
  logic [31:0] bad_addr;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_req(trap_req), .trap_taken(trap_taken), .bad_addr(bad_addr)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        trap;
    logic [31:0] pc;
    logic        set_bad;
    logic [31:0] bad;
  } ev_t;
  ev_t ev_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural outcome of a redirect/trap, straight from the priority rules.
  function automatic ev_t make_ev(input bit redir, input logic [31:0] tgt, input bit trp);
    ev_t e;
    e.trap = trp; e.pc = TV; e.set_bad = 1'b0; e.bad = 32'h0;
    if (!trp && redir) begin
`ifdef PC_MISALIGN_TRAP_EN
      if (tgt[1:0] != 2'b00) begin
        e.trap = 1'b1; e.set_bad = 1'b1; e.bad = tgt;
      end else begin
        e.pc = tgt;
      end
`else
      e.pc = {tgt[31:2], 2'b00};
`endif
    end
    return e;
  endfunction

  // Driver + memory model state
  bit          rst_drv;
  bit          pend;
  logic [31:0] paddr;
  int          cnt;
  bit          zero_wait;
  int          lat_lo, lat_hi;
  bit          junk_en;
  bit          spacing_chk;

  task automatic drive_cycle(input bit rdy, input bit redir, input logic [31:0] tgt, input bit trp);
    @(negedge clk);
    rst = rst_drv;
    if (rst_drv) pend = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (pend) begin
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(paddr);
        pend        = 1'b0;
      end else begin
        cnt--;
      end
    end else if (junk_en && $urandom_range(0, 19) == 0) begin
      imem_rvalid = 1'b1;
    end
    imem_gnt        = !pend && (zero_wait || $urandom_range(0, 2) != 0);
    instr_ready     = rdy;
    redirect_valid  = redir;
    redirect_target = tgt;
    trap_req        = trp;
    if (redir || trp) ev_q.push_back(make_ev(redir, tgt, trp));
    #1;
    if (imem_req && imem_gnt) begin
      pend  = 1'b1;
      paddr = imem_addr;
      cnt   = zero_wait ? 0 : int'($urandom_range(lat_lo, lat_hi));
    end
  endtask

  // Monitor / scoreboard state
  int          cyc = 0;
  int          deliveries = 0;
  int          last_del_cyc = -1;
  logic [31:0] exp_pc;
  bit          tt_pend, outst, prev_stall, prev_hold, flush;
  logic [31:0] bad_cur, prev_addr, prev_instr, prev_ipc;
  ev_t         ev;

  always @(negedge clk) begin
    #2;
    cyc++;
    if (rst) begin
      exp_pc = RV; tt_pend = 1'b0; bad_cur = 32'h0; outst = 1'b0;
      prev_stall = 1'b0; prev_hold = 1'b0; last_del_cyc = -1;
      ev_q.delete();
    end else begin
      check("trap_taken", 32'(trap_taken), 32'(tt_pend));
      check("bad_addr", bad_addr, bad_cur);
      if (prev_stall) check("addr_stable", imem_addr, prev_addr);
      if (imem_req) check("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
      if (outst) check("one_outstanding", 32'(imem_req), 32'd0);
      if (instr_valid) check("req_in_hold", 32'(imem_req), 32'd0);
      if (prev_hold) begin
        check("hold_valid", 32'(instr_valid), 32'd1);
        check("hold_instr", instr, prev_instr);
        check("hold_pc", instr_pc, prev_ipc);
      end
      flush = redirect_valid || trap_req;
      if (flush) begin
        if (ev_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL ev_queue: redirect seen with empty expectation queue");
        end else begin
          ev = ev_q.pop_front();
          exp_pc  = ev.pc;
          tt_pend = ev.trap;
          if (ev.set_bad) bad_cur = ev.bad;
        end
      end else begin
        tt_pend = 1'b0;
        if (instr_valid && instr_ready) begin
          check("instr_pc", instr_pc, exp_pc);
          check("instr", instr, mem_word(exp_pc));
          if (spacing_chk && last_del_cyc >= 0) check("spacing", 32'(cyc - last_del_cyc), 32'd3);
          last_del_cyc = cyc;
          deliveries++;
          exp_pc = exp_pc + 32'd4;
        end
      end
      prev_hold  = instr_valid && !instr_ready && !flush;
      prev_stall = imem_req && !imem_gnt;
      prev_addr  = imem_addr;
      prev_instr = instr;
      prev_ipc   = instr_pc;
      if (imem_rvalid) outst = 1'b0;
      if (imem_req && imem_gnt) outst = 1'b1;
    end
  end

  initial begin
    bit found;
    logic [31:0] t;
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0; trap_req = 1'b0;
    rst_drv = 1'b1; pend = 1'b0; paddr = 32'h0; cnt = 0;
    zero_wait = 1'b1; lat_lo = 0; lat_hi = 0; junk_en = 1'b0; spacing_chk = 1'b0;

    repeat (3) drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", imem_addr, RV);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_trap_taken", 32'(trap_taken), 32'd0);
    check("rst_bad_addr", bad_addr, 32'h0);

    // Zero-wait memory, decode always ready
    rst_drv = 1'b0;
    spacing_chk = 1'b1;
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, RV);
    repeat (13) drive_cycle(1'b1, 1'b0, 32'h0, 1'b0);
    spacing_chk = 1'b0;

    // Decode stalls in HOLD
    repeat (8) drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (8) drive_cycle(1'b1, 1'b0, 32'h0, 1'b0);

    // Redirect while a fetch is outstanding
    zero_wait = 1'b0; lat_lo = 2; lat_hi = 2;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive_cycle(1'b1, 1'b0, 32'h0, 1'b0);
      found = pend;
    end
    check("wait_grant", 32'(found), 32'd1);
    drive_cycle(1'b1, 1'b1, 32'h0000_0200, 1'b0);
    repeat (15) drive_cycle(1'b1, 1'b0, 32'h0, 1'b0);

    // Trap and redirect together while holding an instruction
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
      found = instr_valid;
    end
    check("wait_hold", 32'(found), 32'd1);
    drive_cycle(1'b1, 1'b1, 32'h0000_0300, 1'b1);
    repeat (15) drive_cycle(1'b1, 1'b0, 32'h0, 1'b0);

    // Misaligned redirect target
    drive_cycle(1'b1, 1'b1, 32'h0000_0202, 1'b0);
    repeat (15) drive_cycle(1'b1, 1'b0, 32'h0, 1'b0);

    // PC wrap-around
    zero_wait = 1'b1;
    drive_cycle(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
    repeat (15) drive_cycle(1'b1, 1'b0, 32'h0, 1'b0);

    // Randomized traffic
    zero_wait = 1'b0; lat_lo = 0; lat_hi = 3; junk_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      drive_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0, t, $urandom_range(0, 29) == 0);
    end

    // Reset in the middle of traffic
    junk_en = 1'b0;
    rst_drv = 1'b1;
    repeat (2) drive_cycle(1'b1, 1'b0, 32'h0, 1'b0);
    rst_drv = 1'b0;
    repeat (20) drive_cycle(1'b1, 1'b0, 32'h0, 1'b0);
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b0);

    check("deliveries_made", 32'(deliveries > 100), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
